// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the hardwired control unit: opcodes, FSM state encoding,
// instruction classes and the DataPath strobe bundle.
package cpu_ctrl_pkg;

   localparam int unsigned OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T1W  = 4'd3,
      ST_T2   = 4'd4,
      ST_T3   = 4'd5,
      ST_T4   = 4'd6,
      ST_T5   = 4'd7,
      ST_HALT = 4'd8
   } state_e;

   typedef enum logic [2:0] {
      CL_R    = 3'd0,
      CL_I    = 3'd1,
      CL_U    = 3'd2,
      CL_NOP  = 3'd3,
      CL_HALT = 3'd4,
      CL_ILL  = 3'd5
   } class_e;

   typedef struct packed {
      logic pc_out;
      logic zlow_out;
      logic mdr_out;
      logic mar_in;
      logic zlow_in;
      logic pc_in;
      logic mdr_in;
      logic ir_in;
      logic y_in;
      logic inc_pc;
      logic read;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic c_out;
   } strobe_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Control-unit <-> DataPath bundle: IR/handshake inputs and the control strobes.
interface ctrl_sequencer_if #(
   parameter int unsigned IRW = 32,
   parameter int unsigned OPW = 5
);
   logic [IRW-1:0] ir;
   logic           mem_done;
   logic PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC, Read;
   logic Gra, Grb, Grc, Rin, Rout, Cout;
   logic [OPW-1:0] alu_op;
   logic           run;
   logic           fault;

   modport master (
      input  ir, mem_done,
      output PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC, Read,
      output Gra, Grb, Grc, Rin, Rout, Cout, alu_op, run, fault
   );

   modport slave (
      output ir, mem_done,
      input  PCout, Zlowout, MDRout, MARin, Zlowin, PCin, MDRin, IRin, Yin, IncPC, Read,
      input  Gra, Grb, Grc, Rin, Rout, Cout, alu_op, run, fault
   );
endinterface

// File: rtl/ctrl_decode.sv
// Opcode decoder: maps ir[31:27] to an instruction class and the ALU operation
// used in its execute step (immediate forms reuse the register-form opcode).
module ctrl_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPW = 5
) (
   input  logic [OPW-1:0] opcode,
   output class_e         op_class,
   output logic [OPW-1:0] alu_op
);

   always_comb begin
      op_class = CL_ILL;
      alu_op   = '0;
      unique case (OPC_W'(opcode))
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
            op_class = CL_R;
            alu_op   = opcode;
         end
         OP_ADDI: begin op_class = CL_I; alu_op = OPW'(OP_ADD); end
         OP_ANDI: begin op_class = CL_I; alu_op = OPW'(OP_AND); end
         OP_ORI:  begin op_class = CL_I; alu_op = OPW'(OP_OR);  end
         OP_NEG, OP_NOT: begin
            op_class = CL_U;
            alu_op   = opcode;
         end
         OP_NOP:  op_class = CL_NOP;
         OP_HALT: op_class = CL_HALT;
         default: op_class = CL_ILL;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2 with memory-wait state T1W,
// execute T3-T5 per instruction class, halt/fault handling.
module ctrl_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned OPW      = 5,
   parameter int unsigned IRW      = 32,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic clock,
   input  logic clear,
   ctrl_sequencer_if.master bus
);

   localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   state_e         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic           fault_q, fault_nx;
   strobe_t        strb;
   logic [OPW-1:0] alu_c;
   class_e         op_class;
   logic [OPW-1:0] dec_alu;
   logic           unused_ir_bits;

   assign unused_ir_bits = ^bus.ir[IRW-OPW-1:0];

   ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode   (bus.ir[IRW-1 -: OPW]),
      .op_class (op_class),
      .alu_op   (dec_alu)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         state   <= ST_RST;
         cnt     <= '0;
         fault_q <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         fault_q <= fault_nx;
      end
   end

   // Next state plus Moore decode of strobes from state and opcode class
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      fault_nx = fault_q;
      strb     = '0;
      alu_c    = '0;
      unique case (state)
         ST_RST: begin
            cnt_nx   = '0;
            fault_nx = 1'b0;
            state_nx = ST_T0;
         end
         ST_T0: begin
            strb.pc_out  = 1'b1;
            strb.mar_in  = 1'b1;
            strb.inc_pc  = 1'b1;
            strb.zlow_in = 1'b1;
            state_nx     = ST_T1;
         end
         ST_T1: begin
            strb.zlow_out = 1'b1;
            strb.pc_in    = 1'b1;
            strb.read     = 1'b1;
            strb.mdr_in   = 1'b1;
            if (bus.mem_done) begin
               state_nx = ST_T2;
            end else begin
               state_nx = ST_T1W;
               cnt_nx   = CW'(1);
            end
         end
         ST_T1W: begin
            strb.read   = 1'b1;
            strb.mdr_in = 1'b1;
            if (bus.mem_done) begin
               state_nx = ST_T2;
            end else if (MAX_WAIT != 0 && cnt == CW'(MAX_WAIT)) begin
               state_nx = ST_HALT;
               fault_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         ST_T2: begin
            strb.mdr_out = 1'b1;
            strb.ir_in   = 1'b1;
            state_nx     = ST_T3;
         end
         ST_T3: begin
            unique case (op_class)
               CL_R, CL_I: begin
                  strb.grb   = 1'b1;
                  strb.r_out = 1'b1;
                  strb.y_in  = 1'b1;
                  state_nx   = ST_T4;
               end
               CL_U: begin
                  strb.grb     = 1'b1;
                  strb.r_out   = 1'b1;
                  strb.zlow_in = 1'b1;
                  alu_c        = dec_alu;
                  state_nx     = ST_T4;
               end
               CL_NOP:  state_nx = ST_T0;
               CL_HALT: state_nx = ST_HALT;
               default: begin
                  state_nx = ST_HALT;
                  fault_nx = 1'b1;
               end
            endcase
         end
         ST_T4: begin
            unique case (op_class)
               CL_R: begin
                  strb.grc     = 1'b1;
                  strb.r_out   = 1'b1;
                  strb.zlow_in = 1'b1;
                  alu_c        = dec_alu;
                  state_nx     = ST_T5;
               end
               CL_I: begin
                  strb.c_out   = 1'b1;
                  strb.zlow_in = 1'b1;
                  alu_c        = dec_alu;
                  state_nx     = ST_T5;
               end
               CL_U: begin
                  strb.zlow_out = 1'b1;
                  strb.gra      = 1'b1;
                  strb.r_in     = 1'b1;
                  state_nx      = ST_T0;
               end
               default: state_nx = ST_T0;
            endcase
         end
         ST_T5: begin
            strb.zlow_out = 1'b1;
            strb.gra      = 1'b1;
            strb.r_in     = 1'b1;
            state_nx      = ST_T0;
         end
         ST_HALT: state_nx = ST_HALT;
         default: state_nx = ST_RST;
      endcase
   end

   assign bus.PCout   = strb.pc_out;
   assign bus.Zlowout = strb.zlow_out;
   assign bus.MDRout  = strb.mdr_out;
   assign bus.MARin   = strb.mar_in;
   assign bus.Zlowin  = strb.zlow_in;
   assign bus.PCin    = strb.pc_in;
   assign bus.MDRin   = strb.mdr_in;
   assign bus.IRin    = strb.ir_in;
   assign bus.Yin     = strb.y_in;
   assign bus.IncPC   = strb.inc_pc;
   assign bus.Read    = strb.read;
   assign bus.Gra     = strb.gra;
   assign bus.Grb     = strb.grb;
   assign bus.Grc     = strb.grc;
   assign bus.Rin     = strb.r_in;
   assign bus.Rout    = strb.r_out;
   assign bus.Cout    = strb.c_out;
   assign bus.alu_op  = alu_c;
   assign bus.run     = (state != ST_RST) && (state != ST_HALT);
   assign bus.fault   = fault_q;

endmodule
